wbu_queue: RTL and testbench

- Parametrised write-back stage between the load/store stage and the register file.
- Selects the result from NSRC source buses (memory, ALU, CSR, PC+4, ...) and buffers completed instructions in a DEPTH-entry in-order queue.
- Retires one entry per cycle to the regfile write port and provides a youngest-first forwarding lookup over pending entries.
- Generalises the single-entry write-back unit: source count, data width, buffering depth, retire stall and forwarding are all new.

---
 rtl/wbu_queue_pkg.sv | 34 +++
 rtl/wbu_queue_src_mux.sv | 29 ++
 rtl/wbu_queue.sv | 169 ++++++++++++++++
 tb/tb_wbu_queue.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbu_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wbu_queue_pkg
//  Description : Shared write-back definitions: register address width,
//                default data width, result-source select encodings and the
//                packed queue entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package wbu_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN_DEF   = 32;

    // Result source select encodings
    localparam int SEL_MEM = 0;
    localparam int SEL_ALU = 1;
    localparam int SEL_CSR = 2;
    localparam int SEL_PC4 = 3;

    // One completed instruction waiting for the regfile port (default width)
    typedef struct packed {
        logic [XLEN_DEF-1:0]   pc;
        logic [XLEN_DEF-1:0]   wdata;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wena;
    } wbu_entry_t;

    // Select width for n sources; a single source still needs one select bit
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : wbu_queue_pkg
`default_nettype wire

// File: rtl/wbu_queue_src_mux.sv
`default_nettype none
// ============================================================================
//  Module      : wbu_src_mux
//  Description : Indexed NSRC:1 result-source multiplexer. Select values
//                at or beyond NSRC fall back to source 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module wbu_src_mux #(
    parameter int XLEN = 32,
    parameter int NSRC = 4,
    parameter int SELW = 2
) (
    input  logic [SELW-1:0]      sel_i,
    input  logic [NSRC*XLEN-1:0] src_i,
    output logic [XLEN-1:0]      data_o
);

    // Source 0 is the default so any unmatched select lands there
    always_comb begin
        data_o = src_i[0 +: XLEN];
        for (int k = 1; k < NSRC; k++) begin
            if (sel_i == SELW'(k)) begin
                data_o = src_i[k*XLEN +: XLEN];
            end
        end
    end

endmodule : wbu_src_mux
`default_nettype wire

// File: rtl/wbu_queue.sv
`default_nettype none
// ============================================================================
//  Module      : wbu_queue
//  Description : Write-back stage with result-source selection, a DEPTH-entry
//                in-order completion queue, one-per-cycle retirement to the
//                regfile port and a youngest-first forwarding lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module wbu_queue
    import wbu_queue_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NSRC  = 4,
    parameter  int DEPTH = 4,
    localparam int SELW  = sel_width(NSRC),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_reg_wena,
    input  logic [SELW-1:0]       i_reg_sel,
    input  logic [NSRC*XLEN-1:0]  i_src_data,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [XLEN-1:0]       i_pc,
    input  logic                  i_stall,
    output logic [XLEN-1:0]       o_reg_wdata,
    output logic [REG_ADDR_W-1:0] o_reg_waddr,
    output logic                  o_reg_wena,
    output logic                  o_done,
    output logic [XLEN-1:0]       o_done_pc,
    input  logic [REG_ADDR_W-1:0] i_fwd_raddr,
    output logic                  o_fwd_hit,
    output logic [XLEN-1:0]       o_fwd_data,
    output logic [CNT_W-1:0]      o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Same field order as wbu_entry_t, sized by this instance's XLEN
    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       wdata;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wena;
    } entry_t;

    entry_t           entry_q [DEPTH];
    logic [DEPTH-1:0] valid_q,  valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic [XLEN-1:0]  sel_data;
    logic             nonempty;
    logic             full;
    logic             retire;
    logic             accept;
    entry_t           head;
    entry_t           new_entry;

    logic             fwd_hit;
    logic [XLEN-1:0]  fwd_data;
    logic [PTR_W-1:0] scan_idx;

    wbu_src_mux #(
        .XLEN (XLEN),
        .NSRC (NSRC),
        .SELW (SELW)
    ) u_src_mux (
        .sel_i  (i_reg_sel),
        .src_i  (i_src_data),
        .data_o (sel_data)
    );

    assign nonempty = (count_q != '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign retire   = nonempty && !i_stall;
    // A retiring head frees a slot in the same cycle, so a full queue
    // can still accept when the regfile port is free.
    assign o_ready  = !full || retire;
    assign accept   = i_valid && o_ready;

    assign head = entry_q[rd_ptr_q];

    // x0 is hard-wired zero: never let an rd=0 entry write or forward
    assign new_entry.pc    = i_pc;
    assign new_entry.wdata = sel_data;
    assign new_entry.rd    = i_rd;
    assign new_entry.wena  = i_reg_wena && (i_rd != '0);

    // Retire outputs come straight from the head; data is forced to zero
    // while empty so nothing stale shows during or after reset.
    assign o_done      = retire;
    assign o_reg_wena  = retire && head.wena;
    assign o_reg_wdata = nonempty ? head.wdata : '0;
    assign o_reg_waddr = nonempty ? head.rd    : '0;
    assign o_done_pc   = nonempty ? head.pc    : '0;
    assign o_count     = count_q;
    assign o_fwd_hit   = fwd_hit;
    assign o_fwd_data  = fwd_data;

    // Pointer, occupancy and valid-bit next state
    always_comb begin
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Clear before set: when full, the retiring slot is the one refilled
        if (retire) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (accept) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        case ({accept, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, discarded asynchronously on reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload storage; contents only matter while the slot is valid
    always_ff @(posedge i_clk) begin
        if (accept) begin
            entry_q[wr_ptr_q] <= new_entry;
        end
    end

    // Forwarding scan from oldest to youngest so the youngest match wins;
    // the entry being accepted this cycle is not yet in storage.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        scan_idx = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && valid_q[scan_idx] &&
                entry_q[scan_idx].wena && (entry_q[scan_idx].rd == i_fwd_raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_q[scan_idx].wdata;
            end
        end
        if (i_fwd_raddr == '0) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end

endmodule : wbu_queue
`default_nettype wire

// File: tb/tb_wbu_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wbu_queue
//  Description : Self-checking bench for wbu_queue (XLEN=32, NSRC=4, DEPTH=4)
//                using a queue-based reference model and directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wbu_queue;
    import wbu_queue_pkg::*;

    localparam int XLEN  = 32;
    localparam int NSRC  = 4;
    localparam int DEPTH = 4;

    logic              clk;
    logic              rst_n;
    logic              valid;
    logic              ready;
    logic              reg_wena;
    logic [1:0]        sel;
    logic [NSRC*XLEN-1:0] src;
    logic [4:0]        rd;
    logic [XLEN-1:0]   pc;
    logic              stall;
    logic [XLEN-1:0]   o_wdata;
    logic [4:0]        o_waddr;
    logic              o_wena;
    logic              o_done;
    logic [XLEN-1:0]   o_done_pc;
    logic [4:0]        fwd_raddr;
    logic              o_fwd_hit;
    logic [XLEN-1:0]   o_fwd_data;
    logic [2:0]        o_count;

    int n_vec = 0;
    int n_err = 0;

    wbu_entry_t mq[$];

    wbu_queue #(
        .XLEN  (XLEN),
        .NSRC  (NSRC),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_reg_wena  (reg_wena),
        .i_reg_sel   (sel),
        .i_src_data  (src),
        .i_rd        (rd),
        .i_pc        (pc),
        .i_stall     (stall),
        .o_reg_wdata (o_wdata),
        .o_reg_waddr (o_waddr),
        .o_reg_wena  (o_wena),
        .o_done      (o_done),
        .o_done_pc   (o_done_pc),
        .i_fwd_raddr (fwd_raddr),
        .o_fwd_hit   (o_fwd_hit),
        .o_fwd_data  (o_fwd_data),
        .o_count     (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [NSRC*XLEN-1:0] s, input logic [1:0] sl);
        int idx;
        idx = int'(sl);
        if (idx >= NSRC) idx = 0;
        return s[idx*XLEN +: XLEN];
    endfunction

    // Reference model: retire from the front, append accepted entries
    always @(posedge clk) begin : model_upd
        int         n;
        bit         ret;
        bit         rdy;
        wbu_entry_t e;
        if (rst_n) begin
            n   = mq.size();
            ret = (n != 0) && !stall;
            rdy = (n < DEPTH) || ret;
            if (ret) void'(mq.pop_front());
            if (valid && rdy) begin
                e.pc    = pc;
                e.wdata = pick(src, sel);
                e.rd    = rd;
                e.wena  = reg_wena && (rd != 5'd0);
                mq.push_back(e);
            end
        end
    end

    always @(negedge rst_n) mq.delete();

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin : compare
        int          n;
        bit          ret;
        bit          eh;
        logic [31:0] ed;
        if (!rst_n) begin
            chk("rst_count", 32'(o_count), 32'd0);
            chk("rst_ready", 32'(ready), 32'd1);
            chk("rst_wena", 32'(o_wena), 32'd0);
            chk("rst_done", 32'(o_done), 32'd0);
            chk("rst_fwd_hit", 32'(o_fwd_hit), 32'd0);
            chk("rst_wdata", o_wdata, 32'd0);
            chk("rst_waddr", 32'(o_waddr), 32'd0);
            chk("rst_done_pc", o_done_pc, 32'd0);
            chk("rst_fwd_data", o_fwd_data, 32'd0);
        end else begin
            n   = mq.size();
            ret = (n != 0) && !stall;
            chk("count", 32'(o_count), 32'(n));
            chk("ready", 32'(ready), 32'((n < DEPTH) || ret));
            chk("done", 32'(o_done), 32'(ret));
            if (n != 0) begin
                chk("wena", 32'(o_wena), 32'(ret && mq[0].wena));
                chk("waddr", 32'(o_waddr), 32'(mq[0].rd));
                chk("wdata", o_wdata, mq[0].wdata);
                chk("done_pc", o_done_pc, mq[0].pc);
            end else begin
                chk("wena_empty", 32'(o_wena), 32'd0);
            end
            eh = 1'b0;
            ed = '0;
            if (fwd_raddr != 5'd0) begin
                for (int i = n - 1; i >= 0; i--) begin
                    if (mq[i].wena && (mq[i].rd == fwd_raddr)) begin
                        eh = 1'b1;
                        ed = mq[i].wdata;
                        break;
                    end
                end
            end
            chk("fwd_hit", 32'(o_fwd_hit), 32'(eh));
            if (eh) chk("fwd_data", o_fwd_data, ed);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Selected source carries d; every other source carries a distinct decoy
    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                         input logic [4:0] r, input logic [31:0] p, input logic we);
        valid    = v;
        sel      = s;
        rd       = r;
        pc       = p;
        reg_wena = we;
        for (int k = 0; k < NSRC; k++) begin
            src[k*XLEN +: XLEN] = (k == int'(s)) ? d : (~d ^ 32'(k));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        fwd_raddr = 5'd0;
        drive(1'b0, 2'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        repeat (3) tick();
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_count", 32'(o_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Pass-through: ALU result to x5, visible the cycle after accept
        drive(1'b1, 2'(SEL_ALU), 32'h0000_1234, 5'd5, 32'h0000_0100, 1'b1);
        tick();
        valid = 1'b0;
        #1;
        chk("pt_done", 32'(o_done), 32'd1);
        chk("pt_wena", 32'(o_wena), 32'd1);
        chk("pt_waddr", 32'(o_waddr), 32'd5);
        chk("pt_wdata", o_wdata, 32'h0000_1234);
        chk("pt_done_pc", o_done_pc, 32'h0000_0100);
        tick();
        chk("pt_count", 32'(o_count), 32'd0);

        // Fill while stalled, then drain in push order
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 32'h0000_0F00 + 32'(i), 5'(8 + i), 32'h200 + 32'(4 * i), 1'b1);
            tick();
        end
        chk("fill_ready", 32'(ready), 32'd0);
        chk("fill_count", 32'(o_count), 32'd4);
        drive(1'b1, 2'd2, 32'hBAD0_0000, 5'd20, 32'h300, 1'b1);
        tick();
        valid = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_order", o_wdata, 32'h0000_0F00 + 32'(i));
            tick();
        end

        // Full with simultaneous accept/retire across pointer wrap
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd0, 32'h0000_5000 + 32'(i), 5'(16 + i), 32'h400 + 32'(4 * i), 1'b1);
            tick();
        end
        stall = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 2'(i % 4), 32'h0000_6000 + 32'(i), 5'(1 + i), 32'h500 + 32'(4 * i), 1'b1);
            #1;
            chk("full_ready", 32'(ready), 32'd1);
            chk("full_count", 32'(o_count), 32'd4);
            chk("full_head", o_wdata, (i < 4) ? 32'h0000_5000 + 32'(i) : 32'h0000_6000 + 32'(i - 4));
            tick();
        end
        valid = 1'b0;
        repeat (5) tick();

        // x0 destination: retires but never writes or forwards
        stall = 1'b1;
        drive(1'b1, 2'd1, 32'h0000_DEAD, 5'd0, 32'h600, 1'b1);
        tick();
        valid     = 1'b0;
        fwd_raddr = 5'd0;
        #1;
        chk("x0_fwd_hit", 32'(o_fwd_hit), 32'd0);
        chk("x0_count", 32'(o_count), 32'd1);
        stall = 1'b0;
        #1;
        chk("x0_done", 32'(o_done), 32'd1);
        chk("x0_wena", 32'(o_wena), 32'd0);
        tick();

        // Forwarding priority: youngest rd=7 entry wins
        stall = 1'b1;
        drive(1'b1, 2'd2, 32'h0000_000A, 5'd7, 32'h700, 1'b1);
        tick();
        drive(1'b1, 2'd3, 32'h0000_000B, 5'd7, 32'h704, 1'b1);
        tick();
        drive(1'b1, 2'd0, 32'h0000_000C, 5'd3, 32'h708, 1'b1);
        tick();
        valid     = 1'b0;
        fwd_raddr = 5'd7;
        #1;
        chk("fwd_prio_hit", 32'(o_fwd_hit), 32'd1);
        chk("fwd_prio_data", o_fwd_data, 32'h0000_000B);
        stall = 1'b0;
        repeat (3) tick();
        chk("fwd_drained_hit", 32'(o_fwd_hit), 32'd0);

        // Mixed traffic: varied valid/stall/select/rd/lookup patterns
        for (int i = 0; i < 60; i++) begin
            drive((i % 3) != 0, 2'(i % 4), 32'(i) * 32'h0101_0101 + 32'h11, 5'((i * 7) % 32),
                  32'h800 + 32'(4 * i), (i % 5) != 4);
            stall     = ((i % 5) == 1) || ((i % 7) == 3) || ((i % 11) > 7);
            fwd_raddr = 5'((i * 3) % 32);
            tick();
        end
        valid = 1'b0;
        stall = 1'b0;
        repeat (5) tick();

        // Asynchronous reset with pending entries
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd1, 32'h0000_9000 + 32'(i), 5'(10 + i), 32'h900 + 32'(4 * i), 1'b1);
            tick();
        end
        valid = 1'b0;
        stall = 1'b0;
        #1;
        chk("pre_rst_done", 32'(o_done), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wena", 32'(o_wena), 32'd0);
        chk("mid_rst_done", 32'(o_done), 32'd0);
        chk("mid_rst_count", 32'(o_count), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_count", 32'(o_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wbu_queue
`default_nettype wire
